demux_channel_counter: RTL and testbench
========================================

// Module: demux_channel_counter
// PURPOSE
//  Downstream consumer of the 1-to-4 demux outputs. Detects rising edges on each demux
//  output line, keeps a saturating event counter per channel, flags illegal multi-hot
//  input, and exposes counts through a registered read port. Gives the demux path a
//  per-channel activity monitor for the datapath and for bench self-checking.
// PARAMETERS
//  CNT_W   8   width of each per-channel event counter (1..16)
// PORTS
//  clk        in   1      system clock, all logic on rising edge
//  rst        in   1      synchronous, active-high reset
//  dmx_o      in   4      demux output lines (expected one-hot or zero)
//  clr        in   1      synchronous clear of counters and sticky flags
//  rd_en      in   1      read request, sampled on clk
//  rd_ch      in   2      channel index to read (0..3)
//  rd_data    out  CNT_W  count of requested channel, valid when rd_valid=1
//  rd_valid   out  1      one-cycle pulse, rd_data valid
//  evt_valid  out  1      one-cycle pulse, an edge was counted last cycle
//  last_ch    out  2      channel index of most recent counted edge
//  sat        out  4      sticky per-channel saturation flags, bit n = channel n
//  err        out  1      sticky: dmx_o had more than one bit set
// BEHAVIOUR
//  Channel index = demux select value that drives the line:
//   ch0 = dmx_o[3] (s=00), ch1 = dmx_o[1] (s=01), ch2 = dmx_o[2] (s=10), ch3 = dmx_o[0] (s=11).
//  Reset (rst=1 at clk edge): all counters 0, prev-input register 0, rd_data 0, rd_valid 0,
//   evt_valid 0, last_ch 0, sat 0, err 0. rst overrides every other input.
//  Edge detect: prev <= dmx_o every cycle; rise = dmx_o & ~prev. A line high on the first
//   cycle after reset counts as an edge. A line held high counts once.
//  Multi-hot: if popcount(dmx_o) > 1 in a cycle, err <= 1 (sticky), no counter updates
//   that cycle, evt_valid <= 0; prev still updates.
//  Count: otherwise, for the single rising channel n: cnt[n] <= cnt[n]+1; if cnt[n] is
//   already 2^CNT_W-1 it holds and sat[n] <= 1. last_ch <= n, evt_valid <= 1 next cycle
//   (also on a saturated edge). No rise -> evt_valid <= 0, last_ch holds.
//  Clear: clr=1 zeroes all cnt, sat, err, last_ch and evt_valid; clr wins over a same-cycle
//   edge (edge is dropped, not counted after). prev is NOT cleared, so no spurious edge.
//  Read: rd_en=1 at edge k -> rd_data = cnt[rd_ch] as held before edge k, rd_valid=1 in
//   cycle k+1 (latency 1). Same-cycle increment of that channel is not reflected. rd_en=0
//   -> rd_valid=0, rd_data holds. Back-to-back reads supported every cycle. Read during clr
//   returns pre-clear value.
//  Counter arithmetic unsigned, CNT_W bits, never wraps.
//  No combinational path from any input to any output.
// TESTING
//  1 rst 2 cycles, dmx_o=0 -> all outputs 0; rd_en,rd_ch=2 -> rd_data=0, rd_valid=1 next cycle.
//  2 drive s sequence 00,01,10,11 through demux (in=1, 0 between) -> cnt=1 each ch;
//    last_ch steps 0,1,2,3; evt_valid pulses 4 times; err=0.
//  3 dmx_o=4'b1000 held 10 cycles -> cnt0=1 only; then 4'b1010 -> err=1, cnt0/cnt1 unchanged.
//  4 CNT_W=4: 17 edges on dmx_o[0] -> cnt3=15, sat=4'b1000, evt_valid on all 17 edges.
//  5 clr same cycle as edge on dmx_o[2] -> cnt2=0, sat=0, err=0, evt_valid=0 next cycle;
//    line held high afterwards -> no extra count.
//  6 rd_en,rd_ch=1 same cycle as ch1 edge (cnt1=5) -> rd_data=5, then re-read -> 6; rst
//    mid-sequence -> all counters 0 on next cycle.

Source files
------------

// File: rtl/demux_channel_counter.sv
`default_nettype none
// ============================================================================
// Module   : demux_channel_counter
// Summary  : Rising-edge event counters for each 1-to-4 demux output line,
//            with a registered read port and sticky saturation/multi-hot flags.
// Revision : 1.0 - initial release
// ============================================================================
module demux_channel_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       dmx_o,
    input  logic             clr,
    input  logic             rd_en,
    input  logic [1:0]       rd_ch,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_valid,
    output logic             evt_valid,
    output logic [1:0]       last_ch,
    output logic [3:0]       sat,
    output logic             err
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    logic [3:0]       r_prev;
    logic [CNT_W-1:0] r_cnt [4];
    logic [CNT_W-1:0] r_rd_data;
    logic             r_rd_valid;
    logic             r_evt_valid;
    logic [1:0]       r_last_ch;
    logic [3:0]       r_sat;
    logic             r_err;

    logic [3:0]       w_rise;
    logic             w_multi;
    logic             w_hit;
    logic [1:0]       w_ch;
    logic [CNT_W-1:0] w_cnt_sel;
    logic             w_at_max;

    assign w_rise    = dmx_o & ~r_prev;
    // Clearing the lowest set bit leaves a non-zero value only when two or more bits are set.
    assign w_multi   = (dmx_o & (dmx_o - 4'd1)) != 4'd0;
    assign w_hit     = |w_rise;
    assign w_cnt_sel = r_cnt[w_ch];
    assign w_at_max  = (w_cnt_sel == c_cnt_max);

    // Channel number is the demux select value that drives the line.
    always_comb begin
        w_ch = 2'd0;
        if (w_rise[3]) begin
            w_ch = 2'd0;
        end else if (w_rise[1]) begin
            w_ch = 2'd1;
        end else if (w_rise[2]) begin
            w_ch = 2'd2;
        end else if (w_rise[0]) begin
            w_ch = 2'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev      <= 4'd0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_evt_valid <= 1'b0;
            r_last_ch   <= 2'd0;
            r_sat       <= 4'd0;
            r_err       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_prev     <= dmx_o;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= r_cnt[rd_ch];
            end

            if (clr) begin
                for (int i = 0; i < 4; i++) begin
                    r_cnt[i] <= '0;
                end
                r_sat       <= 4'd0;
                r_err       <= 1'b0;
                r_last_ch   <= 2'd0;
                r_evt_valid <= 1'b0;
            end else if (w_multi) begin
                r_err       <= 1'b1;
                r_evt_valid <= 1'b0;
            end else if (w_hit) begin
                if (w_at_max) begin
                    r_sat[w_ch] <= 1'b1;
                end else begin
                    r_cnt[w_ch] <= w_cnt_sel + c_cnt_one;
                end
                r_last_ch   <= w_ch;
                r_evt_valid <= 1'b1;
            end else begin
                r_evt_valid <= 1'b0;
            end
        end
    end

    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign evt_valid = r_evt_valid;
    assign last_ch   = r_last_ch;
    assign sat       = r_sat;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_demux_channel_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_channel_counter
// Summary  : Directed bench for demux_channel_counter with a cycle-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_channel_counter;

    localparam int CNT_W = 4;
    localparam int MAXV  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       dmx_o;
    logic             clr;
    logic             rd_en;
    logic [1:0]       rd_ch;
    logic [CNT_W-1:0] rd_data;
    logic             rd_valid;
    logic             evt_valid;
    logic [1:0]       last_ch;
    logic [3:0]       sat;
    logic             err;

    int checks   = 0;
    int failures = 0;
    int evt_seen = 0;
    bit cmp_en   = 1'b0;

    always #5 clk = ~clk;

    demux_channel_counter #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .dmx_o     (dmx_o),
        .clr       (clr),
        .rd_en     (rd_en),
        .rd_ch     (rd_ch),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .evt_valid (evt_valid),
        .last_ch   (last_ch),
        .sat       (sat),
        .err       (err)
    );

    // Model state: plain integers updated at each rising edge from the inputs.
    int       m_cnt [4];
    int       m_rd_data;
    bit       m_rd_valid;
    bit       m_evt;
    bit       m_err;
    int       m_last;
    bit [3:0] m_sat;
    bit [3:0] m_prev;

    function automatic int line_to_ch(int b);
        case (b)
            3:       return 0;
            1:       return 1;
            2:       return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [3:0] demux(int s, bit din);
        logic [3:0] v;
        case (s)
            0:       v = 4'b1000;
            1:       v = 4'b0010;
            2:       v = 4'b0100;
            default: v = 4'b0001;
        endcase
        return din ? v : 4'b0000;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_cnt[i] = 0;
            m_rd_data  = 0;
            m_rd_valid = 0;
            m_evt      = 0;
            m_err      = 0;
            m_last     = 0;
            m_sat      = 0;
            m_prev     = 0;
        end else begin
            logic [3:0] rise;
            int         n;
            rise = dmx_o & ~m_prev;
            n    = 0;
            m_rd_valid = rd_en;
            if (rd_en) m_rd_data = m_cnt[rd_ch];
            if (clr) begin
                for (int i = 0; i < 4; i++) m_cnt[i] = 0;
                m_sat  = 0;
                m_err  = 0;
                m_last = 0;
                m_evt  = 0;
            end else if ($countones(dmx_o) > 1) begin
                m_err = 1;
                m_evt = 0;
            end else if (rise != 4'd0) begin
                for (int b = 0; b < 4; b++) if (rise[b]) n = line_to_ch(b);
                if (m_cnt[n] >= MAXV) m_sat[n] = 1'b1;
                else m_cnt[n] = m_cnt[n] + 1;
                m_last = n;
                m_evt  = 1;
            end else begin
                m_evt = 0;
            end
            m_prev = dmx_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_rd_valid", 32'(rd_valid), 32'(m_rd_valid));
            chk("cyc_rd_data", 32'(rd_data), 32'(m_rd_data));
            chk("cyc_evt_valid", 32'(evt_valid), 32'(m_evt));
            chk("cyc_last_ch", 32'(last_ch), 32'(m_last));
            chk("cyc_sat", 32'(sat), 32'(m_sat));
            chk("cyc_err", 32'(err), 32'(m_err));
            if (evt_valid === 1'b1) evt_seen++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic read_chk(input int ch, input int exp);
        rd_en = 1'b1;
        rd_ch = 2'(ch);
        step(1);
        chk("read_valid", 32'(rd_valid), 32'd1);
        chk($sformatf("read_ch%0d", ch), 32'(rd_data), 32'(exp));
        rd_en = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        dmx_o = 4'd0;
        clr   = 1'b0;
        rd_en = 1'b0;
        rd_ch = 2'd0;

        // Reset state and first read
        step(2);
        cmp_en = 1'b1;
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk("rst_evt_valid", 32'(evt_valid), 32'd0);
        chk("rst_last_ch", 32'(last_ch), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        read_chk(2, 0);

        // One pulse per select value through the demux
        evt_seen = 0;
        for (int s = 0; s < 4; s++) begin
            dmx_o = demux(s, 1'b1);
            step(1);
            chk("seq_evt", 32'(evt_valid), 32'd1);
            chk("seq_last_ch", 32'(last_ch), 32'(s));
            dmx_o = demux(s, 1'b0);
            step(1);
        end
        chk("seq_evt_count", 32'(evt_seen), 32'd4);
        chk("seq_err", 32'(err), 32'd0);
        for (int c = 0; c < 4; c++) chk("model_cnt_seq", 32'(m_cnt[c]), 32'd1);
        for (int c = 0; c < 4; c++) read_chk(c, 1);

        // Held line counts once; multi-hot sets err without counting
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        dmx_o = 4'b1000;
        step(10);
        dmx_o = 4'b1010;
        step(1);
        chk("multi_err", 32'(err), 32'd1);
        chk("multi_evt", 32'(evt_valid), 32'd0);
        dmx_o = 4'b0000;
        step(1);
        read_chk(0, 1);
        read_chk(1, 0);
        chk("model_cnt_hold", 32'(m_cnt[0]), 32'd1);

        // Saturation on channel 3
        for (int e = 0; e < 17; e++) begin
            dmx_o = 4'b0001;
            step(1);
            chk("sat_evt", 32'(evt_valid), 32'd1);
            dmx_o = 4'b0000;
            step(1);
        end
        chk("sat_flags", 32'(sat), 32'b1000);
        read_chk(3, 15);

        // Clear wins over a same-cycle edge; held line adds nothing afterwards
        clr   = 1'b1;
        dmx_o = 4'b0100;
        step(1);
        clr = 1'b0;
        chk("clr_evt", 32'(evt_valid), 32'd0);
        chk("clr_sat", 32'(sat), 32'd0);
        chk("clr_err", 32'(err), 32'd0);
        step(3);
        chk("clr_hold_evt", 32'(evt_valid), 32'd0);
        read_chk(2, 0);
        dmx_o = 4'b0000;
        step(1);

        // Read racing an increment, read during clear, reset mid-sequence
        for (int e = 0; e < 5; e++) begin
            dmx_o = 4'b0010;
            step(1);
            dmx_o = 4'b0000;
            step(1);
        end
        dmx_o = 4'b0010;
        rd_en = 1'b1;
        rd_ch = 2'd1;
        step(1);
        chk("race_rd", 32'(rd_data), 32'd5);
        step(1);
        chk("reread_rd", 32'(rd_data), 32'd6);
        dmx_o = 4'b0000;
        clr   = 1'b1;
        step(1);
        clr = 1'b0;
        chk("clr_read_pre", 32'(rd_data), 32'd6);
        rd_en = 1'b0;
        read_chk(1, 0);
        dmx_o = 4'b1000;
        step(1);
        dmx_o = 4'b0000;
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_evt", 32'(evt_valid), 32'd0);
        for (int c = 0; c < 4; c++) read_chk(c, 0);

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
